// File: rtl/sample_packer_pkg.sv
// Shared types and helpers for the sample packer: FSM state encoding and a popcount.
package sample_packer_pkg;

    localparam int unsigned POPCOUNT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } packer_state_t;

    function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/channel_compactor.sv
// Combinational channel compactor: gathers enabled probe bits, lowest channel to lowest bit,
// and reports how many channels are enabled.
module channel_compactor
    import sample_packer_pkg::*;
#(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic [CHANNELS-1:0] probe_q,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [WORD_W-1:0]   bits_c,
    output logic [CNT_W-1:0]    count_c
);

    always_comb begin
        int unsigned idx;
        bits_c = '0;
        idx    = 0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (chan_en[i]) begin
                bits_c = bits_c | (WORD_W'(probe_q[i]) << idx);
                idx    = idx + 1;
            end
        end
    end

    assign count_c = CNT_W'(popcount(POPCOUNT_MAX_W'(chan_en)));

endmodule

// File: rtl/sample_packer.sv
// Divided-rate probe sampler that packs enabled channels densely into FIFO words.
// Optional trigger (ARMED state, trig_* ports) is built when SAMPLE_PACKER_TRIGGER_EN is defined.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned DIV_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] probe,
    input  logic                acq_enable,
    input  logic [DIV_W-1:0]    clock_divisor,
    input  logic [CHANNELS-1:0] channel_enable,
    input  logic                fifo_full,
`ifdef SAMPLE_PACKER_TRIGGER_EN
    input  logic [CHANNELS-1:0] trig_mask,
    input  logic [CHANNELS-1:0] trig_value,
    output logic                triggered,
`endif
    output logic [WORD_W-1:0]   sample_data,
    output logic                sample_data_avail,
    output logic                overflow
);

    localparam int unsigned ACC_W = 2 * WORD_W - 1;
    localparam int unsigned CNT_W = $clog2(2 * WORD_W);

    if (CHANNELS == 0 || CHANNELS > WORD_W) begin : g_bad_channels
        $error("sample_packer: CHANNELS must be in 1..WORD_W");
    end

    packer_state_t       state_q, state_d;
    logic [CHANNELS-1:0] probe_q, probe_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [DIV_W-1:0]    div_lat_q, div_lat_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                avail_q, avail_d;
    logic                ovf_q, ovf_d;
`ifdef SAMPLE_PACKER_TRIGGER_EN
    logic                trig_q, trig_d;
    logic                match_c;
`endif

    logic [WORD_W-1:0]   comp_bits_c;
    logic [CNT_W-1:0]    comp_cnt_c;
    logic [ACC_W-1:0]    merged_c;
    logic [CNT_W-1:0]    total_c;
    logic                tick_c;
    logic                absorb_c;
    logic                emit_c;
    logic [WORD_W-1:0]   word_c;

    channel_compactor #(
        .CHANNELS (CHANNELS),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) u_compactor (
        .probe_q  (probe_q),
        .chan_en  (en_q),
        .bits_c   (comp_bits_c),
        .count_c  (comp_cnt_c)
    );

    // New sample bits land directly above the valid accumulator bits.
    assign merged_c = acc_q | (ACC_W'(comp_bits_c) << cnt_q);
    assign total_c  = cnt_q + comp_cnt_c;
    assign tick_c   = (div_cnt_q == '0);
`ifdef SAMPLE_PACKER_TRIGGER_EN
    assign match_c  = ((probe_q & trig_mask) == (trig_value & trig_mask));
`endif

    // Next-state, accumulator and output logic.
    always_comb begin
        state_d   = state_q;
        probe_d   = probe;
        en_d      = en_q;
        div_lat_d = div_lat_q;
        div_cnt_d = div_cnt_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        avail_d   = 1'b0;
        ovf_d     = ovf_q;
`ifdef SAMPLE_PACKER_TRIGGER_EN
        trig_d    = trig_q;
`endif
        absorb_c  = 1'b0;
        emit_c    = 1'b0;
        word_c    = '0;

        case (state_q)
            ST_IDLE: begin
                if (acq_enable) begin
                    en_d      = channel_enable;
                    div_lat_d = clock_divisor;
                    div_cnt_d = '0;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
`ifdef SAMPLE_PACKER_TRIGGER_EN
                    trig_d    = 1'b0;
                    state_d   = ST_ARMED;
`else
                    state_d   = ST_RUN;
`endif
                end
            end
            ST_ARMED: begin
`ifdef SAMPLE_PACKER_TRIGGER_EN
                if (!acq_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    div_cnt_d = tick_c ? div_lat_q : div_cnt_q - DIV_W'(1);
                    if (tick_c && match_c) begin
                        absorb_c = 1'b1;
                        trig_d   = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RUN: begin
                if (!acq_enable) begin
                    state_d = ST_FLUSH;
                end else begin
                    div_cnt_d = tick_c ? div_lat_q : div_cnt_q - DIV_W'(1);
                    absorb_c  = tick_c;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                if (cnt_q != '0) begin
                    emit_c = 1'b1;
                    word_c = acc_q[WORD_W-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (absorb_c) begin
            if (total_c >= CNT_W'(WORD_W)) begin
                emit_c = 1'b1;
                word_c = merged_c[WORD_W-1:0];
                acc_d  = merged_c >> WORD_W;
                cnt_d  = total_c - CNT_W'(WORD_W);
            end else begin
                acc_d  = merged_c;
                cnt_d  = total_c;
            end
        end

        // A word emitted into a full FIFO is lost but the accumulator still advances.
        if (emit_c) begin
            if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                avail_d = 1'b1;
                data_d  = word_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            probe_q   <= '0;
            en_q      <= '0;
            div_lat_q <= '0;
            div_cnt_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            avail_q   <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef SAMPLE_PACKER_TRIGGER_EN
            trig_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            probe_q   <= probe_d;
            en_q      <= en_d;
            div_lat_q <= div_lat_d;
            div_cnt_q <= div_cnt_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            avail_q   <= avail_d;
            ovf_q     <= ovf_d;
`ifdef SAMPLE_PACKER_TRIGGER_EN
            trig_q    <= trig_d;
`endif
        end
    end

    assign sample_data       = data_q;
    assign sample_data_avail = avail_q;
    assign overflow          = ovf_q;
`ifdef SAMPLE_PACKER_TRIGGER_EN
    assign triggered         = trig_q;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: scenarios are checked against a bit-queue packing model.
// Trigger scenario is included when SAMPLE_PACKER_TRIGGER_EN is defined.
module tb_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] probe;
    logic        acq_enable;
    logic [7:0]  clock_divisor;
    logic [15:0] channel_enable;
    logic        fifo_full;
    logic [15:0] sample_data;
    logic        sample_data_avail;
    logic        overflow;
`ifdef SAMPLE_PACKER_TRIGGER_EN
    logic [15:0] trig_mask;
    logic [15:0] trig_value;
    logic        triggered;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] stim_p[$];
    logic        stim_f[$];
    logic        exp_av[$];
    logic [15:0] exp_d[$];
    logic        exp_ov[$];
    logic        obs_av[$];
    logic [15:0] obs_d[$];
    logic        obs_ov[$];
    logic [15:0] exp_last;

    sample_packer #(
        .CHANNELS (16),
        .WORD_W   (16),
        .DIV_W    (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .probe             (probe),
        .acq_enable        (acq_enable),
        .clock_divisor     (clock_divisor),
        .channel_enable    (channel_enable),
        .fifo_full         (fifo_full),
`ifdef SAMPLE_PACKER_TRIGGER_EN
        .trig_mask         (trig_mask),
        .trig_value        (trig_value),
        .triggered         (triggered),
`endif
        .sample_data       (sample_data),
        .sample_data_avail (sample_data_avail),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: enabled bits of each sample go into a FIFO of bits; every 16 bits form a word.
    // Entry j describes the outputs seen after edge j of a scenario (edge 0 = start).
    task automatic build_expect(input logic [15:0] en, input int div, input int n_run);
        bit          q[$];
        logic [15:0] w;
        logic        emit;
        logic        ovf;
        exp_av.delete(); exp_d.delete(); exp_ov.delete();
        ovf = 1'b0;
        exp_av.push_back(1'b0); exp_d.push_back(exp_last); exp_ov.push_back(1'b0);
        for (int j = 1; j <= n_run + 2; j++) begin
            emit = 1'b0;
            w    = '0;
            if (j <= n_run && ((j - 1) % (div + 1)) == 0) begin
                for (int c = 0; c < 16; c++) if (en[c]) q.push_back(stim_p[j-1][c]);
                if (q.size() >= 16) begin
                    for (int b = 0; b < 16; b++) w[b] = q.pop_front();
                    emit = 1'b1;
                end
            end else if (j == n_run + 2 && q.size() > 0) begin
                for (int b = 0; b < 16 && q.size() > 0; b++) w[b] = q.pop_front();
                emit = 1'b1;
            end
            if (emit && stim_f[j]) ovf = 1'b1;
            if (emit && !stim_f[j]) exp_last = w;
            exp_av.push_back(emit && !stim_f[j]);
            exp_d.push_back(exp_last);
            exp_ov.push_back(ovf);
        end
    endtask

    // Drives one acquisition (start, n_run active edges, stop, flush) and records outputs.
    task automatic run_scenario(input logic [15:0] en, input int div, input int n_run);
        obs_av.delete(); obs_d.delete(); obs_ov.delete();
        for (int j = 0; j <= n_run + 2; j++) begin
            @(negedge clk);
            acq_enable     = (j <= n_run);
            probe          = (j <= n_run) ? stim_p[j] : 16'($urandom);
            fifo_full      = stim_f[j];
            channel_enable = (j == 0) ? en : 16'($urandom);
            clock_divisor  = (j == 0) ? 8'(div) : 8'($urandom);
            @(posedge clk);
            #1;
            obs_av.push_back(sample_data_avail);
            obs_d.push_back(sample_data);
            obs_ov.push_back(overflow);
        end
        @(negedge clk);
        fifo_full = 1'b0;
    endtask

    task automatic fill_stim(input int n_run, input int full_pct);
        stim_p.delete(); stim_f.delete();
        for (int j = 0; j <= n_run + 2; j++) begin
            stim_p.push_back(16'($urandom));
            stim_f.push_back(($urandom_range(99) < full_pct) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; probe = '0; acq_enable = 1'b0; clock_divisor = '0;
        channel_enable = '0; fifo_full = 1'b0;
`ifdef SAMPLE_PACKER_TRIGGER_EN
        trig_mask = '0; trig_value = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sample_data !== 16'h0000) begin
            n_bad++; $display("FAIL reset_data: got %h want 0000", sample_data);
        end
        n_cmp++;
        if (sample_data_avail !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: avail %b ovf %b want 0 0", sample_data_avail, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = '0;
        @(negedge clk);
    endtask

    task automatic test_full_width();
        fill_stim(20, 0);
        for (int j = 0; j <= 22; j++) stim_p[j] = 16'(j);
        build_expect(16'hFFFF, 0, 20);
        run_scenario(16'hFFFF, 0, 20);
        for (int j = 0; j < exp_av.size(); j++) begin
            n_cmp++;
            if (obs_av[j] !== exp_av[j] || obs_d[j] !== exp_d[j] || obs_ov[j] !== exp_ov[j]) begin
                n_bad++;
                $display("FAIL full_width edge %0d: avail/data/ovf got %b/%h/%b want %b/%h/%b",
                         j, obs_av[j], obs_d[j], obs_ov[j], exp_av[j], exp_d[j], exp_ov[j]);
            end
        end
        n_cmp++;
        if (obs_av[7] !== 1'b1 || obs_d[7] !== 16'd6) begin
            n_bad++; $display("FAIL full_width_latency: edge 7 got %b/%h want 1/0006", obs_av[7], obs_d[7]);
        end
    endtask

    task automatic test_nibble();
        int words;
        fill_stim(4, 0);
        stim_p[0] = 16'hA5A1; stim_p[1] = 16'h5A52; stim_p[2] = 16'hFFF3; stim_p[3] = 16'h0004;
        build_expect(16'h000F, 0, 4);
        run_scenario(16'h000F, 0, 4);
        for (int j = 0; j < exp_av.size(); j++) begin
            n_cmp++;
            if (obs_av[j] !== exp_av[j] || obs_d[j] !== exp_d[j] || obs_ov[j] !== exp_ov[j]) begin
                n_bad++;
                $display("FAIL nibble edge %0d: avail/data/ovf got %b/%h/%b want %b/%h/%b",
                         j, obs_av[j], obs_d[j], obs_ov[j], exp_av[j], exp_d[j], exp_ov[j]);
            end
        end
        words = 0;
        foreach (obs_av[j]) if (obs_av[j] === 1'b1) words++;
        n_cmp++;
        if (words != 1 || obs_d[4] !== 16'h4321) begin
            n_bad++; $display("FAIL nibble_word: %0d words, data %h want 1 word 4321", words, obs_d[4]);
        end
    endtask

    task automatic test_sparse_div();
        int words;
        fill_stim(48, 0);
        build_expect(16'h0005, 2, 48);
        run_scenario(16'h0005, 2, 48);
        for (int j = 0; j < exp_av.size(); j++) begin
            n_cmp++;
            if (obs_av[j] !== exp_av[j] || obs_d[j] !== exp_d[j] || obs_ov[j] !== exp_ov[j]) begin
                n_bad++;
                $display("FAIL sparse_div edge %0d: avail/data/ovf got %b/%h/%b want %b/%h/%b",
                         j, obs_av[j], obs_d[j], obs_ov[j], exp_av[j], exp_d[j], exp_ov[j]);
            end
        end
        words = 0;
        foreach (obs_av[j]) if (obs_av[j] === 1'b1) words++;
        n_cmp++;
        if (words != 2 || obs_av[22] !== 1'b1 || obs_av[46] !== 1'b1) begin
            n_bad++; $display("FAIL sparse_div_rate: %0d words, edge22 %b edge46 %b want 2 1 1",
                              words, obs_av[22], obs_av[46]);
        end
    endtask

    task automatic test_flush();
        fill_stim(3, 0);
        stim_p[0] = 16'h1231; stim_p[1] = 16'hFF02; stim_p[2] = 16'h0003;
        build_expect(16'h000F, 0, 3);
        run_scenario(16'h000F, 0, 3);
        for (int j = 0; j < exp_av.size(); j++) begin
            n_cmp++;
            if (obs_av[j] !== exp_av[j] || obs_d[j] !== exp_d[j] || obs_ov[j] !== exp_ov[j]) begin
                n_bad++;
                $display("FAIL flush edge %0d: avail/data/ovf got %b/%h/%b want %b/%h/%b",
                         j, obs_av[j], obs_d[j], obs_ov[j], exp_av[j], exp_d[j], exp_ov[j]);
            end
        end
        n_cmp++;
        if (obs_av[5] !== 1'b1 || obs_d[5] !== 16'h0321) begin
            n_bad++; $display("FAIL flush_word: got %b/%h want 1/0321", obs_av[5], obs_d[5]);
        end
    endtask

    task automatic test_overflow();
        fill_stim(8, 0);
        stim_f[4] = 1'b1;
        build_expect(16'h000F, 0, 8);
        run_scenario(16'h000F, 0, 8);
        for (int j = 0; j < exp_av.size(); j++) begin
            n_cmp++;
            if (obs_av[j] !== exp_av[j] || obs_d[j] !== exp_d[j] || obs_ov[j] !== exp_ov[j]) begin
                n_bad++;
                $display("FAIL overflow edge %0d: avail/data/ovf got %b/%h/%b want %b/%h/%b",
                         j, obs_av[j], obs_d[j], obs_ov[j], exp_av[j], exp_d[j], exp_ov[j]);
            end
        end
        n_cmp++;
        if (obs_av[4] !== 1'b0 || obs_ov[4] !== 1'b1 || obs_ov[10] !== 1'b1 || obs_av[8] !== 1'b1) begin
            n_bad++; $display("FAIL overflow_sticky: avail4 %b ovf4 %b ovf10 %b avail8 %b want 0 1 1 1",
                              obs_av[4], obs_ov[4], obs_ov[10], obs_av[8]);
        end
        // The next start clears the sticky flag.
        fill_stim(2, 0);
        build_expect(16'h00FF, 0, 2);
        run_scenario(16'h00FF, 0, 2);
        n_cmp++;
        if (obs_ov[0] !== 1'b0 || obs_av[2] !== 1'b1 || obs_d[2] !== {stim_p[1][7:0], stim_p[0][7:0]}) begin
            n_bad++; $display("FAIL overflow_clear: ovf %b avail %b data %h want 0 1 %h",
                              obs_ov[0], obs_av[2], obs_d[2], {stim_p[1][7:0], stim_p[0][7:0]});
        end
    endtask

    task automatic test_random();
        logic [15:0] en;
        int          div;
        int          n_run;
        for (int s = 0; s < 20; s++) begin
            en    = (s % 7 == 6) ? 16'h0000 : 16'($urandom);
            div   = $urandom_range(3);
            n_run = $urandom_range(40, 1);
            fill_stim(n_run, 25);
            build_expect(en, div, n_run);
            run_scenario(en, div, n_run);
            for (int j = 0; j < exp_av.size(); j++) begin
                n_cmp++;
                if (obs_av[j] !== exp_av[j] || obs_d[j] !== exp_d[j] || obs_ov[j] !== exp_ov[j]) begin
                    n_bad++;
                    $display("FAIL random s%0d en %h div %0d edge %0d: got %b/%h/%b want %b/%h/%b",
                             s, en, div, j, obs_av[j], obs_d[j], obs_ov[j], exp_av[j], exp_d[j], exp_ov[j]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        acq_enable = 1'b1; channel_enable = 16'h000F; clock_divisor = 8'd0;
        fifo_full = 1'b1; probe = 16'h0007;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sample_data !== 16'h0000 || sample_data_avail !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: data %h avail %b ovf %b want 0000 0 0",
                              sample_data, sample_data_avail, overflow);
        end
        acq_enable = 1'b0; fifo_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = '0;
        fill_stim(2, 0);
        stim_p[0] = 16'h0009; stim_p[1] = 16'h000A;
        build_expect(16'h000F, 0, 2);
        run_scenario(16'h000F, 0, 2);
        n_cmp++;
        if (obs_av[4] !== 1'b1 || obs_d[4] !== 16'h00A9) begin
            n_bad++; $display("FAIL async_reset_discard: got %b/%h want 1/00a9", obs_av[4], obs_d[4]);
        end
    endtask

`ifdef SAMPLE_PACKER_TRIGGER_EN
    task automatic test_trigger();
        logic [15:0] p[11];
        for (int j = 0; j < 11; j++) p[j] = 16'($urandom);
        for (int j = 0; j < 4; j++) p[j][0] = 1'b0;
        p[4][0] = 1'b1;
        trig_mask = 16'h0001; trig_value = 16'h0001;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            acq_enable     = (j <= 10);
            probe          = (j <= 10) ? p[j] : 16'h0000;
            fifo_full      = 1'b0;
            channel_enable = (j == 0) ? 16'hFFFF : 16'($urandom);
            clock_divisor  = 8'd0;
            @(posedge clk);
            #1;
            if (j >= 1 && j <= 10) begin
                n_cmp++;
                if (j < 5 && (sample_data_avail !== 1'b0 || triggered !== 1'b0)) begin
                    n_bad++; $display("FAIL trigger_pre edge %0d: avail %b trig %b want 0 0",
                                      j, sample_data_avail, triggered);
                end else if (j >= 5 && (sample_data_avail !== 1'b1 || sample_data !== p[j-1]
                                        || triggered !== 1'b1)) begin
                    n_bad++; $display("FAIL trigger_run edge %0d: avail %b data %h trig %b want 1 %h 1",
                                      j, sample_data_avail, sample_data, triggered, p[j-1]);
                end
            end
        end
        exp_last = p[9];
        trig_mask = '0; trig_value = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_width();
        test_nibble();
        test_sparse_div();
        test_flush();
        test_overflow();
        test_random();
        test_async_reset();
`ifdef SAMPLE_PACKER_TRIGGER_EN
        test_trigger();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
